// File: rtl/pcm_pkg.sv
`timescale 1ns/1ps
// pcm_pkg
// Shared definitions for the PCM record/playback sequencer: default widths,
// the controller state encoding and the state_led mapping.
// No ports (package).
package pcm_pkg;

    localparam int DBITS_DEFAULT  = 8;
    localparam int CBITS_DEFAULT  = 20;
    localparam int RD_LAT_DEFAULT = 2;

    // State values double as the LED code, so CLEAR/DRAIN share 2'b11.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        PLAY   = 2'b10,
        CLEAR  = 2'b11
    } state_e;

    localparam logic [1:0] LED_IDLE   = 2'b00;
    localparam logic [1:0] LED_RECORD = 2'b01;
    localparam logic [1:0] LED_PLAY   = 2'b10;
    localparam logic [1:0] LED_CLEAR  = 2'b11;

    function automatic logic [1:0] stateLed(input state_e s);
        logic [1:0] led;
        case (s)
            IDLE:    led = LED_IDLE;
            RECORD:  led = LED_RECORD;
            PLAY:    led = LED_PLAY;
            CLEAR:   led = LED_CLEAR;
            default: led = LED_IDLE;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/btn_edge.sv
`timescale 1ns/1ps
// btn_edge
// Two-flop synchroniser for a raw push-button followed by a rising-edge
// detector. Produces exactly one single-cycle pulse per press.
// Ports:
//   clock   in  system clock
//   reset   in  asynchronous active-low reset
//   btn_i   in  raw (asynchronous) button level
//   press_o out one-cycle pulse on a synchronised rising edge
module btn_edge
    import pcm_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchroniser chain plus one extra flop remembering the previous
    // synchronised level for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pcm_rec_play_ctrl.sv
`timescale 1ns/1ps
// pcm_rec_play_ctrl
// Record/playback sequencer for the PCM microphone sample FIFO. Writes one
// microphone sample per sample tick while recording, reads one sample per
// tick while playing, and clears the FIFO before every new take.
// Ports:
//   clock, reset            system clock, asynchronous active-low reset
//   btn_rec, btn_play       raw buttons; each press toggles record / play
//   sample_tick, mic_data   sample-rate strobe and current mic sample
//   fifo_full, fifo_empty   FIFO flags (valid RD_LAT+1 cycles after a pulse)
//   fifo_dout               FIFO read data (valid RD_LAT cycles after fifo_rd)
//   fifo_wr, fifo_rd        one-cycle FIFO requests, never together
//   fifo_din                write data, held between writes
//   fifo_clr                one-cycle FIFO clear pulse
//   pcm_out, pcm_valid      last played sample and its update strobe
//   sample_count            samples recorded in the current/last take
//   overrun                 sticky: a tick was dropped inside the guard window
//   state_led               00 IDLE, 01 RECORD, 10 PLAY, 11 CLEAR/DRAIN
module pcm_rec_play_ctrl
    import pcm_pkg::*;
#(
    parameter int          DBITS       = DBITS_DEFAULT,
    parameter int          CBITS       = CBITS_DEFAULT,
    parameter int unsigned MAX_SAMPLES = (2**20) - 1,
    parameter int          RD_LAT      = RD_LAT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_rec,
    input  logic             btn_play,
    input  logic             sample_tick,
    input  logic [DBITS-1:0] mic_data,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_dout,
    output logic             fifo_wr,
    output logic             fifo_rd,
    output logic [DBITS-1:0] fifo_din,
    output logic             fifo_clr,
    output logic [DBITS-1:0] pcm_out,
    output logic             pcm_valid,
    output logic [CBITS-1:0] sample_count,
    output logic             overrun,
    output logic [1:0]       state_led
);

    localparam int               GW         = $clog2(RD_LAT + 2);
    localparam logic [GW-1:0]    GUARD_LOAD = GW'(RD_LAT + 1);
    localparam logic [CBITS-1:0] MAX_CNT    = CBITS'(MAX_SAMPLES);

    logic recPress;
    logic playPress;

    state_e           state_q,     state_d;
    logic [GW-1:0]    guard_q,     guard_d;
    logic [GW-1:0]    drain_q,     drain_d;
    logic [RD_LAT-1:0] rdPipe_q,   rdPipe_d;
    logic             stop_q,      stop_d;
    logic             fifoWr_q,    fifoWr_d;
    logic             fifoRd_q,    fifoRd_d;
    logic             fifoClr_q,   fifoClr_d;
    logic [DBITS-1:0] fifoDin_q,   fifoDin_d;
    logic [DBITS-1:0] pcmOut_q,    pcmOut_d;
    logic             pcmValid_q,  pcmValid_d;
    logic [CBITS-1:0] count_q,     count_d;
    logic             overrun_q,   overrun_d;

    logic guardOpen;
    logic tickOk;
    logic readPending;

    btn_edge uRecEdge (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (btn_rec),
        .press_o (recPress)
    );

    btn_edge uPlayEdge (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (btn_play),
        .press_o (playPress)
    );

    // The FIFO flags are stale until RD_LAT+1 cycles after a wr/rd pulse,
    // so a tick is only usable once the guard counter has run out.
    assign guardOpen   = (guard_q == '0);
    assign tickOk      = sample_tick & guardOpen;
    assign readPending = fifoRd_q | (|rdPipe_q);

    // Next-state logic: FSM, guard/drain counters, read-latency pipe and
    // the sample counter. stop_q remembers an exit request that has to
    // wait for the guard window or an outstanding read.
    always_comb begin
        state_d    = state_q;
        guard_d    = guardOpen ? '0 : guard_q - GW'(1);
        drain_d    = drain_q;
        stop_d     = stop_q;
        fifoWr_d   = 1'b0;
        fifoRd_d   = 1'b0;
        fifoClr_d  = 1'b0;
        fifoDin_d  = fifoDin_q;
        pcmOut_d   = pcmOut_q;
        pcmValid_d = 1'b0;
        count_d    = count_q;
        overrun_d  = overrun_q | (sample_tick & ~guardOpen);
        rdPipe_d   = RD_LAT'({rdPipe_q, fifoRd_q});

        // The pipe tail marks the cycle in which fifo_dout is valid for
        // the read issued RD_LAT cycles earlier.
        if (rdPipe_q[RD_LAT-1]) begin
            pcmOut_d   = fifo_dout;
            pcmValid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (recPress) begin
                    state_d   = CLEAR;
                    fifoClr_d = 1'b1;
                    count_d   = '0;
                    drain_d   = GUARD_LOAD;
                end else if (playPress && !fifo_empty) begin
                    state_d = PLAY;
                end
            end

            CLEAR: begin
                stop_d = 1'b0;
                if (drain_q == '0) begin
                    state_d = RECORD;
                end else begin
                    drain_d = drain_q - GW'(1);
                end
            end

            RECORD: begin
                if (recPress || (tickOk && fifo_full) || (count_q == MAX_CNT)) begin
                    stop_d = 1'b1;
                end
                if (stop_d) begin
                    if (guardOpen) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end
                end else if (tickOk) begin
                    fifoDin_d = mic_data;
                    fifoWr_d  = 1'b1;
                    guard_d   = GUARD_LOAD;
                    count_d   = count_q + CBITS'(1);
                end
            end

            PLAY: begin
                if (playPress) begin
                    stop_d = 1'b1;
                end
                if (stop_d) begin
                    if (!readPending) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end
                end else if (tickOk) begin
                    if (!fifo_empty) begin
                        fifoRd_d = 1'b1;
                        guard_d  = GUARD_LOAD;
                    end else if (!readPending) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            guard_q    <= '0;
            drain_q    <= '0;
            rdPipe_q   <= '0;
            stop_q     <= 1'b0;
            fifoWr_q   <= 1'b0;
            fifoRd_q   <= 1'b0;
            fifoClr_q  <= 1'b0;
            fifoDin_q  <= '0;
            pcmOut_q   <= '0;
            pcmValid_q <= 1'b0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            drain_q    <= drain_d;
            rdPipe_q   <= rdPipe_d;
            stop_q     <= stop_d;
            fifoWr_q   <= fifoWr_d;
            fifoRd_q   <= fifoRd_d;
            fifoClr_q  <= fifoClr_d;
            fifoDin_q  <= fifoDin_d;
            pcmOut_q   <= pcmOut_d;
            pcmValid_q <= pcmValid_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
        end
    end

    assign fifo_wr      = fifoWr_q;
    assign fifo_rd      = fifoRd_q;
    assign fifo_clr     = fifoClr_q;
    assign fifo_din     = fifoDin_q;
    assign pcm_out      = pcmOut_q;
    assign pcm_valid    = pcmValid_q;
    assign sample_count = count_q;
    assign overrun      = overrun_q;
    assign state_led    = stateLed(state_q);

endmodule

// File: tb/tb_pcm_rec_play_ctrl.sv
`timescale 1ns/1ps
// tb_pcm_rec_play_ctrl
// Directed bench for the PCM record/playback sequencer with a small
// behavioural FIFO (delayed flags, RD_LAT read latency).
module tb_pcm_rec_play_ctrl;

    localparam int RD_LAT = 2;

    logic        clock;
    logic        reset;
    logic        btn_rec;
    logic        btn_play;
    logic        sample_tick;
    logic [7:0]  mic_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_wr;
    logic        fifo_rd;
    logic [7:0]  fifo_din;
    logic        fifo_clr;
    logic [7:0]  pcm_out;
    logic        pcm_valid;
    logic [19:0] sample_count;
    logic        overrun;
    logic [1:0]  state_led;

    int errorCount = 0;
    int checkCount = 0;

    pcm_rec_play_ctrl #(
        .DBITS       (8),
        .CBITS       (20),
        .MAX_SAMPLES (7),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_rec      (btn_rec),
        .btn_play     (btn_play),
        .sample_tick  (sample_tick),
        .mic_data     (mic_data),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_wr      (fifo_wr),
        .fifo_rd      (fifo_rd),
        .fifo_din     (fifo_din),
        .fifo_clr     (fifo_clr),
        .pcm_out      (pcm_out),
        .pcm_valid    (pcm_valid),
        .sample_count (sample_count),
        .overrun      (overrun),
        .state_led    (state_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one value and report it on a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Behavioural FIFO: two-stage read data, flags delayed by two cycles.
    logic [7:0] fifoMem[$];
    logic [7:0] rdStage;
    logic [7:0] doutQ;
    logic       emptyS1, emptyS2, fullS;
    logic       forceFull;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdStage <= 8'h00;
            doutQ   <= 8'h00;
            emptyS1 <= 1'b1;
            emptyS2 <= 1'b1;
            fullS   <= 1'b0;
        end else begin
            if (fifo_clr) begin
                fifoMem.delete();
            end else begin
                if (fifo_wr) fifoMem.push_back(fifo_din);
                if (fifo_rd && fifoMem.size() > 0) rdStage <= fifoMem.pop_front();
            end
            doutQ   <= rdStage;
            emptyS1 <= (fifoMem.size() == 0);
            emptyS2 <= emptyS1;
            fullS   <= (fifoMem.size() >= 16);
        end
    end

    assign fifo_dout  = doutQ;
    assign fifo_empty = emptyS2;
    assign fifo_full  = fullS | forceFull;

    // Monitor: pulse counts, write spacing and read-to-pcm latency.
    int         cyc = 0;
    int         wrCount = 0;
    int         rdCount = 0;
    int         clrCount = 0;
    int         clearCycles = 0;
    int         pcmCount = 0;
    int         lastWrCyc = -1000;
    logic [7:0] lastWrDin = 8'h00;
    logic [7:0] lastPcm = 8'h00;
    int         rdCycQ[$];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            if (fifo_wr) begin
                checkOutput("wrSpacing", ((cyc - lastWrCyc) >= RD_LAT + 1), 1);
                lastWrCyc = cyc;
                lastWrDin = fifo_din;
                wrCount++;
            end
            if (fifo_rd) begin
                rdCycQ.push_back(cyc);
                rdCount++;
            end
            if (fifo_clr) clrCount++;
            if (state_led == 2'b11) clearCycles++;
            if (pcm_valid) begin
                pcmCount++;
                lastPcm = pcm_out;
                if (rdCycQ.size() > 0) checkOutput("pcmLatency", cyc - rdCycQ.pop_front(), RD_LAT + 1);
                else checkOutput("pcmWithoutRead", 1, 0);
            end
        end
    end

    // Mutual exclusion of the FIFO strobes.
    always @(negedge clock) begin
        if (reset) begin
            assert (!(fifo_wr && fifo_rd)) else begin
                errorCount++;
                $display("[TB] FAIL wrRdExclusive: wr=%0b rd=%0b", fifo_wr, fifo_rd);
            end
            assert (!(fifo_clr && (fifo_wr || fifo_rd))) else begin
                errorCount++;
                $display("[TB] FAIL clrExclusive: clr=%0b wr=%0b rd=%0b", fifo_clr, fifo_wr, fifo_rd);
            end
        end
    end

    typedef struct {
        logic [7:0]  mic;
        logic        full;
        int          gap;
        int          expWr;
        logic [7:0]  expDin;
        logic [19:0] expCount;
        logic        expOverrun;
        logic [1:0]  expLed;
    } recVec_t;

    recVec_t    recVec [18];
    logic [7:0] playExp [5];

    task automatic applyStimulus(input recVec_t v);
        @(negedge clock);
        forceFull   = v.full;
        mic_data    = v.mic;
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        repeat (v.gap) @(negedge clock);
    endtask

    task automatic runRecVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int wrBefore;
            wrBefore = wrCount;
            applyStimulus(recVec[i]);
            checkOutput($sformatf("wrDelta[%0d]", i), wrCount - wrBefore, recVec[i].expWr);
            checkOutput($sformatf("din[%0d]", i), fifo_din, recVec[i].expDin);
            if (recVec[i].expWr == 1) checkOutput($sformatf("wrDin[%0d]", i), lastWrDin, recVec[i].expDin);
            checkOutput($sformatf("count[%0d]", i), sample_count, recVec[i].expCount);
            checkOutput($sformatf("overrun[%0d]", i), overrun, recVec[i].expOverrun);
            checkOutput($sformatf("led[%0d]", i), state_led, recVec[i].expLed);
        end
    endtask

    task automatic pressButtons(input logic r, input logic p);
        @(negedge clock);
        btn_rec  = r;
        btn_play = p;
        repeat (4) @(negedge clock);
        btn_rec  = 1'b0;
        btn_play = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic waitState(input logic [1:0] exp, input int budget, input string name);
        int n;
        n = 0;
        while (state_led !== exp && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, state_led, exp);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".led"},     state_led,    2'b00);
        checkOutput({tag, ".wr"},      fifo_wr,      0);
        checkOutput({tag, ".rd"},      fifo_rd,      0);
        checkOutput({tag, ".clr"},     fifo_clr,     0);
        checkOutput({tag, ".valid"},   pcm_valid,    0);
        checkOutput({tag, ".overrun"}, overrun,      0);
        checkOutput({tag, ".din"},     fifo_din,     0);
        checkOutput({tag, ".pcm"},     pcm_out,      0);
        checkOutput({tag, ".count"},   sample_count, 0);
    endtask

    initial begin
        int rdBefore;
        int pcmBefore;

        //               mic    full  gap  wr din    count  ov    led
        recVec[0]  = '{8'h11, 1'b0, 100, 1, 8'h11, 20'd1, 1'b0, 2'b01};
        recVec[1]  = '{8'h12, 1'b0, 100, 1, 8'h12, 20'd2, 1'b0, 2'b01};
        recVec[2]  = '{8'h13, 1'b0, 100, 1, 8'h13, 20'd3, 1'b0, 2'b01};
        recVec[3]  = '{8'h14, 1'b0, 100, 1, 8'h14, 20'd4, 1'b0, 2'b01};
        recVec[4]  = '{8'h15, 1'b0, 100, 1, 8'h15, 20'd5, 1'b0, 2'b01};
        recVec[5]  = '{8'h31, 1'b0, 100, 1, 8'h31, 20'd1, 1'b0, 2'b01};
        recVec[6]  = '{8'h32, 1'b0, 100, 1, 8'h32, 20'd2, 1'b0, 2'b01};
        recVec[7]  = '{8'h33, 1'b0, 100, 1, 8'h33, 20'd3, 1'b0, 2'b01};
        recVec[8]  = '{8'h34, 1'b1, 100, 0, 8'h33, 20'd3, 1'b0, 2'b00};
        recVec[9]  = '{8'h21, 1'b0, 1,   1, 8'h21, 20'd1, 1'b0, 2'b01};
        recVec[10] = '{8'h22, 1'b0, 100, 0, 8'h21, 20'd1, 1'b1, 2'b01};
        recVec[11] = '{8'h23, 1'b0, 100, 1, 8'h23, 20'd2, 1'b1, 2'b01};
        recVec[12] = '{8'h24, 1'b0, 100, 1, 8'h24, 20'd3, 1'b1, 2'b01};
        recVec[13] = '{8'h25, 1'b0, 100, 1, 8'h25, 20'd4, 1'b1, 2'b01};
        recVec[14] = '{8'h26, 1'b0, 100, 1, 8'h26, 20'd5, 1'b1, 2'b01};
        recVec[15] = '{8'h27, 1'b0, 100, 1, 8'h27, 20'd6, 1'b1, 2'b01};
        recVec[16] = '{8'h28, 1'b0, 100, 1, 8'h28, 20'd7, 1'b1, 2'b00};
        recVec[17] = '{8'h29, 1'b0, 100, 0, 8'h28, 20'd7, 1'b1, 2'b00};
        playExp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

        reset       = 1'b0;
        btn_rec     = 1'b0;
        btn_play    = 1'b0;
        sample_tick = 1'b0;
        mic_data    = 8'h00;
        forceFull   = 1'b0;

        repeat (5) @(negedge clock);
        checkReset("reset");
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // First take: five samples, stopped by a rec press.
        pressButtons(1'b1, 1'b0);
        waitState(2'b01, 50, "enterRecord1");
        checkOutput("clrPulses1", clrCount, 1);
        checkOutput("clearCycles1", clearCycles, RD_LAT + 2);
        runRecVectors(0, 4);
        pressButtons(1'b1, 1'b0);
        waitState(2'b00, 50, "stopRecord1");
        checkOutput("count1", sample_count, 5);
        checkOutput("wrTotal1", wrCount, 5);

        // Playback of the first take; a rec press mid-play is ignored.
        pressButtons(1'b0, 1'b1);
        waitState(2'b10, 50, "enterPlay");
        for (int i = 0; i < 5; i++) begin
            rdBefore = rdCount;
            @(negedge clock);
            sample_tick = 1'b1;
            @(negedge clock);
            sample_tick = 1'b0;
            repeat (100) @(negedge clock);
            checkOutput($sformatf("rdDelta[%0d]", i), rdCount - rdBefore, 1);
            checkOutput($sformatf("pcmOut[%0d]", i), lastPcm, playExp[i]);
            checkOutput($sformatf("pcmCount[%0d]", i), pcmCount, i + 1);
            if (i == 1) begin
                pressButtons(1'b1, 1'b0);
                checkOutput("recIgnoredInPlay", state_led, 2'b10);
            end
        end
        @(negedge clock);
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        repeat (20) @(negedge clock);
        checkOutput("playEndIdle", state_led, 2'b00);
        checkOutput("rdTotal", rdCount, 5);
        pressButtons(1'b0, 1'b1);
        repeat (10) @(negedge clock);
        checkOutput("playEmptyIgnored", state_led, 2'b00);

        // Second take: both buttons together (rec wins), FIFO goes full.
        pressButtons(1'b1, 1'b1);
        waitState(2'b01, 50, "bothPressRecord");
        checkOutput("clrPulses2", clrCount, 2);
        checkOutput("clearCycles2", clearCycles, 2 * (RD_LAT + 2));
        runRecVectors(5, 8);
        forceFull = 1'b0;

        // Third take: dropped tick sets overrun, count saturates at 7.
        pressButtons(1'b1, 1'b0);
        waitState(2'b01, 50, "enterRecord3");
        checkOutput("clrPulses3", clrCount, 3);
        runRecVectors(9, 17);

        // Reset while a read is outstanding.
        pressButtons(1'b0, 1'b1);
        waitState(2'b10, 50, "enterPlay3");
        @(negedge clock);
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        checkOutput("rdPendingBeforeReset", fifo_rd, 1);
        pcmBefore = pcmCount;
        reset = 1'b0;
        #1;
        checkReset("midPlayReset");
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("noPcmAfterReset", pcmCount, pcmBefore);
        checkOutput("idleAfterReset", state_led, 2'b00);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        repeat (30000) @(posedge clock);
        errorCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
